// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: writeback source codes,
// EX forward selects and the MDU scoreboard state encoding.
package core_pkg;

  localparam logic [1:0] WB_SRC_MEM = 2'b01;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } sb_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage register indices in,
// stall/flush/forward controls and performance counters out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_D, rs2_D;
  logic             rs1_used_D, rs2_used_D;
  logic [4:0]       rs1_E, rs2_E, rd_E;
  logic             we_reg_E;
  logic [1:0]       wb_ctrl_E;
  logic [4:0]       rd_M, rd_W;
  logic             we_reg_M, we_reg_W;
  logic             branch_taken_E;
  logic             mdu_start_E;
  logic [4:0]       mdu_rd_E;
  logic             mdu_done;

  logic             stall_F, stall_D;
  logic             flush_D, flush_E;
  logic             forward_1_D, forward_2_D;
  logic [1:0]       fwd_a_E, fwd_b_E;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output rs1_D, rs2_D, rs1_used_D, rs2_used_D, rs1_E, rs2_E, rd_E,
           we_reg_E, wb_ctrl_E, rd_M, rd_W, we_reg_M, we_reg_W,
           branch_taken_E, mdu_start_E, mdu_rd_E, mdu_done,
    input  stall_F, stall_D, flush_D, flush_E, forward_1_D, forward_2_D,
           fwd_a_E, fwd_b_E, mdu_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_used_D, rs2_used_D, rs1_E, rs2_E, rd_E,
           we_reg_E, wb_ctrl_E, rd_M, rd_W, we_reg_M, we_reg_W,
           branch_taken_E, mdu_start_E, mdu_rd_E, mdu_done,
    output stall_F, stall_D, flush_D, flush_E, forward_1_D, forward_2_D,
           fwd_a_E, fwd_b_E, mdu_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_perf_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module perf_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (inc && !(&cnt_reg)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, bypass selection and one-entry MDU scoreboard for the
// 5-stage core; all controls are combinational from stage indices and state.
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  sb_state_t  state_reg, state_next;
  logic [4:0] pend_rd_reg, pend_rd_next;
  logic       pend_v;

  logic [4:0] rs_d [2];
  logic [4:0] rs_e [2];
  logic [1:0] used_d;
  logic [1:0] lu_hit, mdu_hit, fwd_d;
  logic [1:0] fwd_e [2];
  logic       ld_e, struct_hz, stl;

  assign rs_d[0] = bus.rs1_D;
  assign rs_d[1] = bus.rs2_D;
  assign rs_e[0] = bus.rs1_E;
  assign rs_e[1] = bus.rs2_E;
  assign used_d  = {bus.rs2_used_D, bus.rs1_used_D};

  assign pend_v = (state_reg == MDU_WAIT);
  assign ld_e   = bus.we_reg_E && (bus.wb_ctrl_E == WB_SRC_MEM) && (bus.rd_E != 5'd0);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic live_d, m_hit, w_hit;

      // x0 is never a real dependency, so it is filtered before any compare.
      assign live_d      = used_d[gi] && (rs_d[gi] != 5'd0);
      assign lu_hit[gi]  = live_d && ld_e && (rs_d[gi] == bus.rd_E);
      assign mdu_hit[gi] = live_d &&
                           ((pend_v && (rs_d[gi] == pend_rd_reg)) ||
                            (bus.mdu_start_E && (rs_d[gi] == bus.mdu_rd_E)));
      assign fwd_d[gi]   = bus.we_reg_W && (bus.rd_W != 5'd0) && (bus.rd_W == rs_d[gi]);

      assign m_hit       = bus.we_reg_M && (bus.rd_M != 5'd0) && (bus.rd_M == rs_e[gi]);
      assign w_hit       = bus.we_reg_W && (bus.rd_W != 5'd0) && (bus.rd_W == rs_e[gi]);
      assign fwd_e[gi]   = m_hit ? FWD_M : (w_hit ? FWD_W : FWD_REG);
    end
  endgenerate

  assign struct_hz = bus.mdu_start_E && pend_v && !bus.mdu_done;
  assign stl       = (|lu_hit) || (|mdu_hit) || struct_hz;

  // A redirect squashes the dependent instruction anyway, so it overrides stalls.
  assign bus.stall_F     = stl && !bus.branch_taken_E;
  assign bus.stall_D     = stl && !bus.branch_taken_E;
  assign bus.flush_D     = bus.branch_taken_E;
  assign bus.flush_E     = bus.branch_taken_E || stl;
  assign bus.forward_1_D = fwd_d[0];
  assign bus.forward_2_D = fwd_d[1];
  assign bus.fwd_a_E     = fwd_e[0];
  assign bus.fwd_b_E     = fwd_e[1];
  assign bus.mdu_busy    = pend_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= RUN;
      pend_rd_reg <= 5'd0;
    end else begin
      state_reg   <= state_next;
      pend_rd_reg <= pend_rd_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pend_rd_next = pend_rd_reg;
    case (state_reg)
      RUN: begin
        if (bus.mdu_start_E) begin
          state_next   = MDU_WAIT;
          pend_rd_next = bus.mdu_rd_E;
        end
      end
      MDU_WAIT: begin
        // A start without done is held off by the structural stall.
        if (bus.mdu_done) begin
          if (bus.mdu_start_E) begin
            pend_rd_next = bus.mdu_rd_E;
          end else begin
            state_next = RUN;
          end
        end
      end
      default: state_next = RUN;
    endcase
  end

  perf_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bus.stall_D),
    .cnt (bus.stall_cnt)
  );

  perf_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bus.branch_taken_E),
    .cnt (bus.flush_cnt)
  );

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage core. It drives the `flush_E` and `forward_*_D` controls of the ID/EX register, the fetch/decode stall and flush lines, and the EX-stage operand forwarding selects. It also owns a one-entry scoreboard for the multi-cycle multiply/divide unit (MDU), and saturating stall and flush performance counters. It sits beside the pipeline registers and has no datapath of its own.

## Interface
Parameters:
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `rs1_D`, `rs2_D` in 5: source registers of the instruction in decode.
- `rs1_used_D`, `rs2_used_D` in 1: the decode instruction actually reads that source.
- `rs1_E`, `rs2_E`, `rd_E` in 5: register indices in execute.
- `we_reg_E` in 1: register write enable in execute.
- `wb_ctrl_E` in 2: writeback source in execute.
- `rd_M`, `rd_W` in 5: destination registers in memory and writeback.
- `we_reg_M`, `we_reg_W` in 1: register write enables in memory and writeback.
- `branch_taken_E` in 1: a redirect is resolved in EX this cycle.
- `mdu_start_E` in 1: a one-cycle pulse when an MDU op is in EX.
- `mdu_rd_E` in 5: destination register of that MDU op.
- `mdu_done` in 1: one-cycle pulse when the MDU result is written to the register file.
- `stall_F`, `stall_D` out 1: hold the PC and the IF/ID register.
- `flush_D`, `flush_E` out 1: bubble IF/ID and ID/EX.
- `forward_1_D`, `forward_2_D` out 1: WB-to-decode bypass selects.
- `fwd_a_E`, `fwd_b_E` out 2: EX operand selects. `00` = register, `01` = from W, `10` = from M.
- `mdu_busy` out 1: the scoreboard entry is valid.
- `stall_cnt`, `flush_cnt` out CNT_W: performance counters.

## Operation
- Load in EX: `ld_E = we_reg_E & (wb_ctrl_E == WB_SRC_MEM) & (rd_E != 0)`.
- Load-use hazard: `ld_E` is true and `rd_E` matches a used decode source (`rsX_D` with `rsX_used_D` set).
- MDU hazard: a used, non-zero decode source matches `pend_rd` while `pend_v` is set, or matches `mdu_rd_E` while `mdu_start_E` is set.
- Structural hazard: `mdu_start_E` is set, `pend_v` is set, and `mdu_done` is clear.
- Stall condition `stl` = load-use | MDU hazard | structural hazard.
- When `stl` holds and there is no redirect: assert `stall_F = stall_D = 1` and `flush_E = 1`.
- Redirect (`branch_taken_E`):
  - assert `flush_D = flush_E = 1` and force `stall_F = stall_D = 0`;
  - a redirect takes priority over every stall;
  - the MDU scoreboard is not cleared, because the MDU op is older than the branch.
- Decode bypass: `forward_1_D = we_reg_W & (rd_W != 0) & (rd_W == rs1_D)`. `forward_2_D` is the same with `rs2_D`.
- EX bypass, evaluated for `rs1_E` (giving `fwd_a_E`) and `rs2_E` (giving `fwd_b_E`), highest priority first:
  - M match (`we_reg_M`, `rd_M != 0`, `rd_M == rsX_E`) selects `10`;
  - otherwise W match selects `01`;
  - otherwise `00`.
- MDU ops travel with `we_reg_E = 0`. They write only through `mdu_done`.
- Scoreboard FSM:
  - states: RUN (`pend_v = 0`) and MDU_WAIT (`pend_v = 1`);
  - RUN → MDU_WAIT on `mdu_start_E`; latch `pend_rd <= mdu_rd_E`;
  - MDU_WAIT → RUN on `mdu_done` with no `mdu_start_E`;
  - MDU_WAIT with `mdu_done` and `mdu_start_E` in the same cycle: stay in MDU_WAIT, latch the new `pend_rd`, and do not stall;
  - MDU_WAIT with `mdu_start_E` but no `mdu_done`: structural stall; the scoreboard does not change;
  - `mdu_done` while in RUN is ignored.
- `mdu_busy = pend_v`.
- Counters:
  - `stall_cnt` increments each cycle `stall_D` is 1;
  - `flush_cnt` increments each cycle `branch_taken_E` is 1;
  - both saturate at all-ones.

## Timing
- All stall, flush and forward outputs are combinational from the current inputs and state, and are valid in the same cycle.
- The scoreboard and the counters update on the rising edge of `clk`.
- Load-use stall lasts exactly 1 cycle. On the next cycle the load is in M, and the dependent instruction is served by `fwd_*_E = 10` (or by W).
- MDU dependency stall lasts from detection up to and including the `mdu_done` cycle. The dependent instruction is released on the cycle after `mdu_done`, and reads the written register (or `forward_*_D` if `rd_W` matches).
- Register x0 never causes a stall or a forward.
- Reset outputs:
  - state RUN, `pend_v = 0`, `pend_rd = 0`;
  - `stall_cnt = flush_cnt = 0`;
  - every combinational output follows from these values; with the pipeline registers also in reset, all outputs are 0.
- Reset in the middle of MDU_WAIT returns to RUN immediately. A `mdu_done` that arrives later is ignored.

## Structure
- A shared package `core_pkg` holds:
  - `WB_SRC_MEM = 2'b01`;
  - the forward-select constants `FWD_REG`, `FWD_W`, `FWD_M`;
  - the FSM state enum.
- One sub-module, `perf_sat_counter` (parameter `CNT_W`, ports `clk`, `rst`, `inc`, `cnt`), is instantiated twice.

## Test plan
- Load-use: load with `rd_E = 5` and `rs1_D = 5` used → `stall_F = stall_D = flush_E = 1` for 1 cycle; next cycle `fwd_a_E = 10`; `stall_cnt = 1`.
- Redirect during a load-use stall: both conditions in the same cycle → `flush_D = flush_E = 1`, `stall_F = 0`; `flush_cnt` increments.
- MDU: `mdu_start_E` with `mdu_rd_E = 7`, then `mdu_done` 4 cycles later; decode reads x7 in the cycle after the start → stall for 4 cycles, released the cycle after `mdu_done`; `mdu_busy` is 1 for 4 cycles.
- Back-to-back MDU: a second `mdu_start_E` in the same cycle as `mdu_done` → no stall; `pend_rd` updates.
- Forwarding priority: `rd_M = rd_W = rs2_E = 3`, both writes enabled → `fwd_b_E = 10`. With `rd_W = rs1_D = 0` → `forward_1_D = 0`.
- Reset during MDU_WAIT, then a stray `mdu_done` → RUN, counters 0, no stall.
